// File: rtl/seq_detect_ff_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_detect_ff_if : serial-bit / detection-status bundle            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface seq_detect_ff_if #(
  parameter int CNT_W = 8
) ();
  logic             din;
  logic             en;
  logic             clr;
  logic             det;
  logic [CNT_W-1:0] count;
  logic             fill;

  modport master (
    output din,
    output en,
    output clr,
    input  det,
    input  count,
    input  fill
  );

  modport slave (
    input  din,
    input  en,
    input  clr,
    output det,
    output count,
    output fill
  );
endinterface
`default_nettype wire

// File: rtl/seq_detect_ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_detect_ff : overlapping LEN-bit serial pattern detector with   |
// |                 saturating hit counter                             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_detect_ff #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ff_if.slave    bus
);

  localparam int                SEEN_W      = $clog2(LEN + 1);
  localparam logic [SEEN_W-1:0] C_SEEN_MAX  = SEEN_W'(LEN);
  localparam logic [SEEN_W-1:0] C_SEEN_LAST = SEEN_W'(LEN - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  logic [LEN-1:0]    hist_q, hist_d;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic              fill_q, fill_d;
  logic              det_q, det_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [LEN-1:0]    w_shifted;
  logic              w_match;

  always_comb begin
    w_shifted = {hist_q[LEN-2:0], bus.din};
    hist_d    = hist_q;
    seen_d    = seen_q;
    det_d     = 1'b0;
    w_match   = 1'b0;
    count_d   = count_q;

    if (bus.en) begin
      hist_d = w_shifted;
      if (seen_q != C_SEEN_MAX) begin
        seen_d = seen_q + 1'b1;
      end
      // The bit being taken now is the LEN-th or later, so the window is fully real data.
      w_match = (w_shifted == PATTERN) && (seen_q >= C_SEEN_LAST);
      det_d   = w_match;
    end

    if (bus.clr) begin
      count_d = '0;
    end else if (w_match && (count_q != C_CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end

    fill_d = (seen_d == C_SEEN_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      seen_q  <= '0;
      fill_q  <= 1'b0;
      det_q   <= 1'b0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      count_q <= count_d;
    end
  end

  assign bus.det   = det_q;
  assign bus.count = count_q;
  assign bus.fill  = fill_q;

endmodule
`default_nettype wire
